multdiv_unit: RTL and testbench

- Multicycle signed integer multiply/divide unit.
- Sits beside the execute stage of the pipelined processor inside the top-level wrapper, which the system testbench drives with clock and reset only.
- The execute/stall logic issues one-cycle start pulses, holds the pipeline until data_resultRDY, then forwards data_result and data_exception to the X/M latch.
- Multiply uses radix-4 modified Booth; divide uses non-restoring division on magnitudes.

---
 rtl/multdiv_unit_if.sv | 33 +++
 rtl/multdiv_unit.sv | 160 ++++++++++++++++
 tb/tb_multdiv_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// Issue/response bundle between the execute stage and the multiply/divide unit.
// The execute side drives operands and start pulses; the unit returns a result with a completion strobe.
interface multdiv_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output data_operandA,
      output data_operandB,
      output ctrl_MULT,
      output ctrl_DIV,
      input  data_result,
      input  data_exception,
      input  data_resultRDY
   );

   modport slave (
      input  data_operandA,
      input  data_operandB,
      input  ctrl_MULT,
      input  ctrl_DIV,
      output data_result,
      output data_exception,
      output data_resultRDY
   );
endinterface

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (radix-4 Booth, WIDTH/2 cycles) and divide
// (non-restoring on magnitudes, WIDTH cycles) with a one-cycle completion strobe.
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input logic           clock,
   input logic           reset,
   multdiv_unit_if.slave bus
);
   localparam int AW = 2*WIDTH + 2;
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    MULT_LAST = CW'(WIDTH/2 - 1);
   localparam logic [CW-1:0]    DIV_LAST  = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t           state;
   state_t           next_state;
   logic             start;
   logic [CW-1:0]    count;

   logic [AW-1:0]    acc;
   logic [AW-1:0]    mcand;
   logic [WIDTH:0]   mplier;
   logic [AW-1:0]    booth_term;
   logic [AW-1:0]    acc_next;
   logic [WIDTH-1:0] mult_result;
   logic             mult_exc;

   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] operand_b_mag;
   logic             neg_quo;
   logic             div_zero;
   logic             div_ovf;
   logic [WIDTH-1:0] div_result;
   logic             div_exc;

   logic [WIDTH-1:0] result;
   logic             exception;

   assign start = bus.ctrl_MULT | bus.ctrl_DIV;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A start pulse overrides every state, so an in-flight operation is simply abandoned.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: next_state = IDLE;
         MULT: if (count == MULT_LAST) next_state = DONE;
         DIV:  if (count == DIV_LAST)  next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (bus.ctrl_MULT) begin
         next_state = MULT;
      end else if (bus.ctrl_DIV) begin
         next_state = DIV;
      end
   end

   // Booth digit from multiplier bits {2i+1, 2i, 2i-1}; mcand is pre-shifted by 2i.
   always_comb begin
      booth_term = '0;
      case (mplier[2:0])
         3'b001, 3'b010: booth_term = mcand;
         3'b011:         booth_term = mcand << 1;
         3'b100:         booth_term = -(mcand << 1);
         3'b101, 3'b110: booth_term = -mcand;
         default:        booth_term = '0;
      endcase
      acc_next    = acc + booth_term;
      mult_result = acc_next[WIDTH-1:0];
      mult_exc    = (acc_next[AW-1:WIDTH] != {(AW-WIDTH){acc_next[WIDTH-1]}});
   end

   // 2*rem stays within WIDTH+1 bits because |rem| never exceeds the divisor.
   always_comb begin
      rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
      if (rem[WIDTH]) begin
         rem_next = rem_shift + {1'b0, divisor_mag};
      end else begin
         rem_next = rem_shift - {1'b0, divisor_mag};
      end
      quo_next = {quo[WIDTH-2:0], ~rem_next[WIDTH]};
      if (div_zero) begin
         div_result = '0;
      end else if (neg_quo) begin
         div_result = -quo_next;
      end else begin
         div_result = quo_next;
      end
      div_exc = div_zero | div_ovf;
   end

   assign dividend_mag  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
   assign operand_b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count       <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         rem         <= '0;
         quo         <= '0;
         divisor_mag <= '0;
         neg_quo     <= 1'b0;
         div_zero    <= 1'b0;
         div_ovf     <= 1'b0;
         result      <= '0;
         exception   <= 1'b0;
      end else if (start) begin
         count       <= '0;
         acc         <= '0;
         mcand       <= {{(AW-WIDTH){bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
         mplier      <= {bus.data_operandB, 1'b0};
         rem         <= '0;
         quo         <= dividend_mag;
         divisor_mag <= operand_b_mag;
         neg_quo     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
         div_zero    <= (bus.data_operandB == '0);
         div_ovf     <= (bus.data_operandA == MIN_INT) && (bus.data_operandB == '1);
      end else if (state == MULT) begin
         count  <= count + 1'b1;
         acc    <= acc_next;
         mcand  <= mcand << 2;
         mplier <= {{2{mplier[WIDTH]}}, mplier[WIDTH:2]};
         if (next_state == DONE) begin
            result    <= mult_result;
            exception <= mult_exc;
         end
      end else if (state == DIV) begin
         count <= count + 1'b1;
         rem   <= rem_next;
         quo   <= quo_next;
         if (next_state == DONE) begin
            result    <= div_result;
            exception <= div_exc;
         end
      end
   end

   assign bus.data_result    = result;
   assign bus.data_exception = exception;
   assign bus.data_resultRDY = (state == DONE);
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed cases plus randomized operations
// checked against plain-arithmetic expectations, including aborts and async reset.
module tb_multdiv_unit;
   localparam int W = 32;
   localparam int MULT_LAT = W/2;
   localparam int DIV_LAT = W;
   localparam logic [W-1:0] MIN_INT = 32'h8000_0000;
   localparam logic [W-1:0] MAX_INT = 32'h7FFF_FFFF;

   typedef struct {
      logic [W-1:0] result;
      logic         exc;
      int           due;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cycle = 0;
   int   total = 0;
   int   bad = 0;
   exp_t expq[$];
   logic [W-1:0] last_result = '0;
   logic         last_exc = 1'b0;

   multdiv_unit_if #(.WIDTH(W)) bus ();

   multdiv_unit #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Expected outcome straight from signed integer arithmetic.
   function automatic exp_t model(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b, input int edge0);
      exp_t   e;
      longint p;
      int     q;
      if (is_mult) begin
         p = longint'($signed(a)) * longint'($signed(b));
         e.result = p[W-1:0];
         e.exc = (p != longint'($signed(p[W-1:0])));
         e.due = edge0 + MULT_LAT;
      end else begin
         if (b == '0) begin
            e.result = '0;
            e.exc = 1'b1;
         end else if (a == MIN_INT && b == '1) begin
            e.result = MIN_INT;
            e.exc = 1'b1;
         end else begin
            q = $signed(a) / $signed(b);
            e.result = q;
            e.exc = 1'b0;
         end
         e.due = edge0 + DIV_LAT;
      end
      return e;
   endfunction

   task automatic applyStimulus(input bit mult, input bit div, input logic [W-1:0] a, input logic [W-1:0] b);
      int edge0;
      @(posedge clock);
      #1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT = mult;
      bus.ctrl_DIV = div;
      @(posedge clock);
      #1;
      edge0 = cycle;
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV = 1'b0;
      bus.data_operandA = $urandom();
      bus.data_operandB = $urandom();
      expq.delete();
      expq.push_back(model(mult, a, b, edge0));
   endtask

   task automatic waitDone();
      for (int i = 0; i < DIV_LAT + 10 && expq.size() != 0; i++) @(posedge clock);
      @(posedge clock);
   endtask

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 32'd1;
         3: return MIN_INT;
         4: return MAX_INT;
         5: return 32'($signed($urandom_range(0, 200)) - 100);
         default: return $urandom();
      endcase
   endfunction

   // Monitor: strobes are matched against the scoreboard; otherwise outputs must hold.
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (bus.data_resultRDY) begin
            if (expq.size() == 0) begin
               checkOutput("unexpected_rdy", 32'd1, 32'd0);
            end else begin
               e = expq.pop_front();
               checkOutput("rdy_cycle", cycle, e.due);
               checkOutput("result", bus.data_result, e.result);
               checkOutput("exception", {31'd0, bus.data_exception}, {31'd0, e.exc});
               last_result = e.result;
               last_exc = e.exc;
            end
         end else begin
            checkOutput("hold_result", bus.data_result, last_result);
            checkOutput("hold_exception", {31'd0, bus.data_exception}, {31'd0, last_exc});
            if (expq.size() != 0 && cycle > expq[0].due) begin
               checkOutput("rdy_timeout", cycle, expq[0].due);
               void'(expq.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit do_mult;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      checkOutput("reset_result", bus.data_result, '0);
      checkOutput("reset_exception", {31'd0, bus.data_exception}, '0);
      checkOutput("reset_rdy", {31'd0, bus.data_resultRDY}, '0);
      reset = 1'b0;

      applyStimulus(1'b1, 1'b0, 32'd6, -32'sd7);
      waitDone();
      applyStimulus(1'b1, 1'b0, MAX_INT, 32'd2);
      waitDone();
      applyStimulus(1'b1, 1'b0, MIN_INT, '1);
      waitDone();
      applyStimulus(1'b0, 1'b1, -32'sd43, 32'd5);
      waitDone();
      applyStimulus(1'b0, 1'b1, 32'd100, -32'sd7);
      waitDone();
      applyStimulus(1'b0, 1'b1, 32'd1234, '0);
      waitDone();
      applyStimulus(1'b0, 1'b1, MIN_INT, '1);
      waitDone();

      // Abort: DIV sampled five edges after the MULT start.
      applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
      repeat (3) @(posedge clock);
      applyStimulus(1'b0, 1'b1, 32'd100, 32'd10);
      waitDone();

      // Simultaneous start, then a DIV during which 27 must hold.
      applyStimulus(1'b1, 1'b1, 32'd9, 32'd3);
      waitDone();
      applyStimulus(1'b0, 1'b1, 32'd77, 32'd7);
      waitDone();

      // Async reset mid-divide, between edges 20 and 21.
      applyStimulus(1'b0, 1'b1, 32'd5000, 32'd3);
      repeat (19) @(posedge clock);
      #3;
      expq.delete();
      last_result = '0;
      last_exc = 1'b0;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_result", bus.data_result, '0);
      checkOutput("async_reset_exception", {31'd0, bus.data_exception}, '0);
      checkOutput("async_reset_rdy", {31'd0, bus.data_resultRDY}, '0);
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'd2, 32'd2);
      waitDone();

      // Randomized operations, some aborted by the next start.
      for (int n = 0; n < 40; n++) begin
         do_mult = $urandom_range(0, 1);
         applyStimulus(do_mult, ~do_mult, pickOperand(), pickOperand());
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(0, 40)) @(posedge clock);
         end else begin
            waitDone();
            repeat ($urandom_range(0, 3)) @(posedge clock);
         end
      end
      waitDone();
      repeat (3) @(posedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
